event_sequencer: RTL and testbench



---
 rtl/avs_det_pkg.sv | 24 ++
 rtl/evt_record_slot.sv | 56 +++++
 rtl/event_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_event_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/avs_det_pkg.sv
// rtl/avs_det_pkg.sv - shared state encoding, widths and record layout for event_sequencer (EVT_PEAK_EN adds the peak field)
package avs_det_pkg;

   localparam int ENERGY_W = 64;
   localparam int TS_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_WARMUP  = 3'd0,
      ST_ARMED   = 3'd1,
      ST_PENDING = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_HOLDOFF = 3'd4
   } evt_state_t;

   // Record layout, MSB to LSB: start | dur | peak (peak present only with EVT_PEAK_EN)
   function automatic int rec_w(input int ts_w);
`ifdef EVT_PEAK_EN
      return 2 * ts_w + ENERGY_W;
`else
      return 2 * ts_w;
`endif
   endfunction

endpackage

// File: rtl/evt_record_slot.sv
// rtl/evt_record_slot.sv - single-entry valid/ready record holding register with sticky overflow flag
module evt_record_slot #(
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              rec_ready,
   output logic              rec_valid,
   output logic [DATA_W-1:0] rec_data,
   output logic              rec_overflow
);

   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              xfer;

   // A transfer frees the slot in the same cycle, so a coincident push loads instead of overflowing
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      xfer    = valid_q & rec_ready;
      if (xfer) begin
         valid_d = 1'b0;
      end
      if (push) begin
         if (!valid_q || xfer) begin
            valid_d = 1'b1;
            data_d  = push_data;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // Slot registers; overflow is sticky until reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rec_valid    = valid_q;
   assign rec_data     = data_q;
   assign rec_overflow = ovf_q;

endmodule

// File: rtl/event_sequencer.sv
// rtl/event_sequencer.sv - STA/LTA event sequencing FSM with threshold freeze and event records (EVT_PEAK_EN adds recPeak)
module event_sequencer
   import avs_det_pkg::*;
#(
   parameter int CONFIRM_LEN = 3,
   parameter int MIN_DUR     = 50,
   parameter int HOLDOFF_LEN = 200,
   parameter int REL_SHIFT   = 1,
   parameter int TS_W        = TS_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                sampleValid,
   input  logic                initDone,
   input  logic [ENERGY_W-1:0] shortEnergy,
   input  logic [ENERGY_W-1:0] TH,
   output logic                freeze,
   output logic                eventDetected,
   output logic                recValid,
   input  logic                recReady,
   output logic [TS_W-1:0]     recStart,
   output logic [TS_W-1:0]     recDur,
   output logic                recOverflow
`ifdef EVT_PEAK_EN
   ,
   output logic [ENERGY_W-1:0] recPeak
`endif
);

   localparam int              REC_W       = rec_w(TS_W);
   localparam logic [TS_W-1:0] CONFIRM_CNT = TS_W'(CONFIRM_LEN);
   localparam logic [TS_W-1:0] MIN_CNT     = TS_W'(MIN_DUR);
   localparam logic [TS_W-1:0] HOLD_CNT    = TS_W'(HOLDOFF_LEN);
   localparam logic [TS_W-1:0] DUR_MAX     = '1;

   evt_state_t                 state_q, state_d;
   logic [TS_W-1:0]            sample_cnt_q, sample_cnt_d;
   logic [TS_W-1:0]            start_q, start_d;
   logic [TS_W-1:0]            dur_q, dur_d, dur_inc;
   logic [TS_W-1:0]            phase_cnt_q, phase_cnt_d;
   logic                       freeze_q, freeze_d;
   logic                       evt_q, evt_d;
   logic                       push;
   logic                       trig, rel;
   logic signed [ENERGY_W-1:0] energy_s, th_s, rel_lvl;
   logic [REC_W-1:0]           push_data, rec_data;

   // Signed trigger and hysteretic release comparisons
   always_comb begin
      energy_s = $signed(shortEnergy);
      th_s     = $signed(TH);
      rel_lvl  = th_s >>> REL_SHIFT;
      trig     = energy_s > th_s;
      rel      = energy_s < rel_lvl;
   end

   // Next-state logic; phase_cnt counts confirmations in PENDING and elapsed samples in HOLDOFF
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      start_d      = start_q;
      dur_d        = dur_q;
      phase_cnt_d  = phase_cnt_q;
      push         = 1'b0;
      dur_inc      = (dur_q == DUR_MAX) ? dur_q : dur_q + TS_W'(1);
      if (sampleValid) begin
         sample_cnt_d = sample_cnt_q + TS_W'(1);
         case (state_q)
            ST_WARMUP: begin
               if (initDone) begin
                  state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (trig) begin
                  start_d     = sample_cnt_q;
                  dur_d       = '0;
                  phase_cnt_d = TS_W'(1);
                  state_d     = (CONFIRM_LEN <= 1) ? ST_ACTIVE : ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (trig) begin
                  phase_cnt_d = phase_cnt_q + TS_W'(1);
                  if (phase_cnt_d >= CONFIRM_CNT) begin
                     state_d = ST_ACTIVE;
                  end
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_ACTIVE: begin
               dur_d = dur_inc;
               if (rel && (dur_inc >= MIN_CNT)) begin
                  push        = 1'b1;
                  phase_cnt_d = '0;
                  state_d     = ST_HOLDOFF;
               end
            end
            ST_HOLDOFF: begin
               phase_cnt_d = phase_cnt_q + TS_W'(1);
               if (phase_cnt_d >= HOLD_CNT) begin
                  state_d = ST_ARMED;
               end
            end
            default: begin
               state_d = ST_WARMUP;
            end
         endcase
      end
      freeze_d = (state_d == ST_PENDING) || (state_d == ST_ACTIVE) || (state_d == ST_HOLDOFF);
      evt_d    = (state_d == ST_ACTIVE);
   end

   // FSM state, counters and registered status outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_WARMUP;
         sample_cnt_q <= '0;
         start_q      <= '0;
         dur_q        <= '0;
         phase_cnt_q  <= '0;
         freeze_q     <= 1'b0;
         evt_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         start_q      <= start_d;
         dur_q        <= dur_d;
         phase_cnt_q  <= phase_cnt_d;
         freeze_q     <= freeze_d;
         evt_q        <= evt_d;
      end
   end

`ifdef EVT_PEAK_EN
   logic signed [ENERGY_W-1:0] peak_q, peak_d, peak_nx;
   logic                       tracking;

   // Running maximum of energy from the first triggering sample through the release sample
   always_comb begin
      tracking = (state_q == ST_PENDING) || (state_q == ST_ACTIVE);
      peak_nx  = (tracking && (peak_q > energy_s)) ? peak_q : energy_s;
      peak_d   = peak_q;
      if (sampleValid && (tracking || ((state_q == ST_ARMED) && trig))) begin
         peak_d = peak_nx;
      end
   end

   // Peak register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign push_data = {start_q, dur_inc, peak_nx};
   assign recPeak   = rec_data[ENERGY_W-1:0];
   assign recDur    = rec_data[ENERGY_W +: TS_W];
   assign recStart  = rec_data[ENERGY_W+TS_W +: TS_W];
`else
   assign push_data = {start_q, dur_inc};
   assign recDur    = rec_data[0 +: TS_W];
   assign recStart  = rec_data[TS_W +: TS_W];
`endif

   evt_record_slot #(
      .DATA_W(REC_W)
   ) u_slot (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_data   (push_data),
      .rec_ready   (recReady),
      .rec_valid   (recValid),
      .rec_data    (rec_data),
      .rec_overflow(recOverflow)
   );

   assign freeze        = freeze_q;
   assign eventDetected = evt_q;

endmodule

// File: tb/tb_event_sequencer.sv
// tb/tb_event_sequencer.sv - directed self-checking bench for event_sequencer (EVT_PEAK_EN enables recPeak checks)
module tb_event_sequencer;

   logic        clock;
   logic        reset;
   logic        sampleValid;
   logic        initDone;
   logic [63:0] shortEnergy;
   logic [63:0] TH;
   logic        freeze;
   logic        eventDetected;
   logic        recValid;
   logic        recReady;
   logic [31:0] recStart;
   logic [31:0] recDur;
   logic        recOverflow;
`ifdef EVT_PEAK_EN
   logic [63:0] recPeak;
`endif

   int total;
   int bad;
   int idx;

   event_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .sampleValid  (sampleValid),
      .initDone     (initDone),
      .shortEnergy  (shortEnergy),
      .TH           (TH),
      .freeze       (freeze),
      .eventDetected(eventDetected),
      .recValid     (recValid),
      .recReady     (recReady),
      .recStart     (recStart),
      .recDur       (recDur),
      .recOverflow  (recOverflow)
`ifdef EVT_PEAK_EN
      ,
      .recPeak      (recPeak)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic sample(input logic [63:0] e);
      shortEnergy = e;
      sampleValid = 1'b1;
      @(posedge clock);
      #1;
      sampleValid = 1'b0;
      idx++;
   endtask

   task automatic samples(input logic [63:0] e, input int n);
      for (int i = 0; i < n; i++) sample(e);
   endtask

   task automatic idle_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      idx         = 0;
      reset       = 1'b0;
      sampleValid = 1'b0;
      initDone    = 1'b0;
      shortEnergy = '0;
      TH          = 64'd10;
      recReady    = 1'b0;
      repeat (3) idle_cycle();

      check_eq("rst_freeze", 64'(freeze), 64'd0);
      check_eq("rst_evt", 64'(eventDetected), 64'd0);
      check_eq("rst_valid", 64'(recValid), 64'd0);
      check_eq("rst_start", 64'(recStart), 64'd0);
      check_eq("rst_dur", 64'(recDur), 64'd0);
      check_eq("rst_ovf", 64'(recOverflow), 64'd0);
      reset = 1'b1;
      idle_cycle();

      // warm-up ignores large energy
      samples(64'd1000, 3);
      check_eq("warmup_evt", 64'(eventDetected), 64'd0);
      check_eq("warmup_freeze", 64'(freeze), 64'd0);

      TH       = 64'd100;
      initDone = 1'b1;
      sample(64'd10);

      // aborted confirmation
      sample(64'd500);
      check_eq("pend_freeze", 64'(freeze), 64'd1);
      check_eq("pend_evt", 64'(eventDetected), 64'd0);
      sample(64'd500);
      sample(64'd50);
      check_eq("abort_freeze", 64'(freeze), 64'd0);
      check_eq("abort_valid", 64'(recValid), 64'd0);

      // full event starting at sample 1000
      while (idx < 1000) sample(64'd10);
      samples(64'd500, 2);
      check_eq("pre_confirm_evt", 64'(eventDetected), 64'd0);
      sample(64'd500);
      check_eq("confirm_evt", 64'(eventDetected), 64'd1);
      samples(64'd500, 77);
      sample(64'd10);
      check_eq("ev1_valid", 64'(recValid), 64'd1);
      check_eq("ev1_start", 64'(recStart), 64'd1000);
      check_eq("ev1_dur", 64'(recDur), 64'd78);
      check_eq("ev1_evt_drop", 64'(eventDetected), 64'd0);
      check_eq("ev1_hold_freeze", 64'(freeze), 64'd1);
`ifdef EVT_PEAK_EN
      check_eq("ev1_peak", recPeak, 64'd500);
`endif

      // holdoff ignores triggers, including the exit sample
      samples(64'd500, 199);
      check_eq("hold_freeze", 64'(freeze), 64'd1);
      check_eq("hold_evt", 64'(eventDetected), 64'd0);
      sample(64'd500);
      check_eq("hold_exit_freeze", 64'(freeze), 64'd0);

      // second event, early release below MIN_DUR ignored, then dropped record
      samples(64'd500, 10);
      sample(64'd10);
      check_eq("early_rel_evt", 64'(eventDetected), 64'd1);
      samples(64'd500, 49);
      sample(64'd10);
      check_eq("ovf_set", 64'(recOverflow), 64'd1);
      check_eq("ovf_valid", 64'(recValid), 64'd1);
      check_eq("ovf_start_held", 64'(recStart), 64'd1000);
      check_eq("ovf_dur_held", 64'(recDur), 64'd78);
`ifdef EVT_PEAK_EN
      check_eq("ovf_peak_held", recPeak, 64'd500);
`endif
      recReady = 1'b1;
      idle_cycle();
      recReady = 1'b0;
      check_eq("xfer_valid", 64'(recValid), 64'd0);
      check_eq("ovf_sticky", 64'(recOverflow), 64'd1);

      // reset mid-ACTIVE
      samples(64'd10, 200);
      samples(64'd500, 10);
      check_eq("mid_active_evt", 64'(eventDetected), 64'd1);
      reset = 1'b0;
      #2;
      check_eq("arst_evt", 64'(eventDetected), 64'd0);
      check_eq("arst_freeze", 64'(freeze), 64'd0);
      check_eq("arst_valid", 64'(recValid), 64'd0);
      check_eq("arst_ovf", 64'(recOverflow), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      idx   = 0;
      sample(64'd500);
      check_eq("post_rst_warmup_freeze", 64'(freeze), 64'd0);
      check_eq("post_rst_valid", 64'(recValid), 64'd0);

      // event A held, event B pushed coincident with transfer
      samples(64'd500, 20);
      sample(64'd700);
      samples(64'd500, 34);
      sample(64'd10);
      check_eq("evA_start", 64'(recStart), 64'd1);
      check_eq("evA_dur", 64'(recDur), 64'd53);
`ifdef EVT_PEAK_EN
      check_eq("evA_peak", recPeak, 64'd700);
`endif
      samples(64'd10, 200);
      samples(64'd300, 30);
      sample(64'd900);
      samples(64'd300, 29);
      recReady = 1'b1;
      sample(64'd10);
      recReady = 1'b0;
      check_eq("evB_valid", 64'(recValid), 64'd1);
      check_eq("evB_start", 64'(recStart), 64'd257);
      check_eq("evB_dur", 64'(recDur), 64'd58);
      check_eq("evB_no_ovf", 64'(recOverflow), 64'd0);
`ifdef EVT_PEAK_EN
      check_eq("evB_peak", recPeak, 64'd900);
`endif
      recReady = 1'b1;
      idle_cycle();
      recReady = 1'b0;
      check_eq("evB_xfer_valid", 64'(recValid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
